astable_osc_core: RTL and testbench

- Programmable digital astable multivibrator: a free-running square wave with independently set HIGH and LOW durations and a clock prescaler.
- Downstream of the top-level I/O shim. The shim drives the settings from ui_in/uio_in and routes osc_out, period_done and the cycle counter to uo_out.
- Provides glitch-free setting updates: new settings take effect only at a period boundary.

---
 rtl/astable_pkg.sv | 28 ++
 rtl/astable_prescaler.sv | 29 ++
 rtl/astable_osc_core.sv | 149 ++++++++++++++
 tb/tb_astable_osc_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/astable_pkg.sv
// Shared types for the programmable astable oscillator.
// Latency: n/a (types and helpers only).
// Backpressure: n/a; contents are the state enum, default widths and the settings struct.
package astable_pkg;

  localparam int LEN_W = 8;  // high/low phase length, in prescaled ticks
  localparam int PRE_W = 8;  // prescaler setting; divide ratio is prescale+1
  localparam int CNT_W = 8;  // completed-period counter

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } osc_state_t;

  // One settings set; used for both the active and the pending (shadow) copy.
  typedef struct packed {
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] low_len;
    logic [PRE_W-1:0] prescale;
  } osc_cfg_t;

  // Phase counter value on which a phase ends: max(len,1)-1.
  function automatic logic [LEN_W-1:0] last_idx(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - LEN_W'(1);
  endfunction

endpackage

// File: rtl/astable_prescaler.sv
// Prescale counter: tick every div+1 cycles of clk while clr is low.
// Latency: tick is combinational from the counter; clr takes effect at the next edge.
// Backpressure: none; clr holds the counter at 0.
// Ports: clk, rst_n (async active-low), clr (sync clear), div (terminal count), tick (out).
module astable_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  assign tick = (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/astable_osc_core.sv
// Programmable astable multivibrator: square wave with separate HIGH/LOW lengths and a prescaler.
// Latency: en/load act at the next clk edge; new settings apply at IDLE or the LOW->HIGH boundary.
// Backpressure: none; load always succeeds, the last load before a boundary wins.
// Ports: clk, rst_n (async active-low), en (run level), high_len/low_len/prescale (settings),
//        load (capture strobe), osc_out, period_done, cycle_cnt, busy (all registered).
module astable_osc_core #(
  // Widths must match the package defaults, since the settings struct is shared.
  parameter int LEN_W = astable_pkg::LEN_W,
  parameter int PRE_W = astable_pkg::PRE_W,
  parameter int CNT_W = astable_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [PRE_W-1:0] prescale,
  input  logic             load,
  output logic             osc_out,
  output logic             period_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             busy
);

  import astable_pkg::*;

  osc_state_t       state, state_nxt;
  osc_cfg_t         act, act_nxt;
  osc_cfg_t         pend, pend_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic [LEN_W-1:0] phase, phase_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             osc_nxt, done_nxt, busy_nxt;
  logic             apply;
  logic             tick;
  logic             clr;

  // Prescaler is held at 0 while idle and cleared on the disabling edge,
  // so every phase starts from a fresh tick count.
  assign clr = (state == IDLE) || !en;

  astable_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .div   (act.prescale),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      act         <= '0;
      pend        <= '0;
      pend_vld    <= 1'b0;
      phase       <= '0;
      cycle_cnt   <= '0;
      osc_out     <= 1'b0;
      period_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      act         <= act_nxt;
      pend        <= pend_nxt;
      pend_vld    <= pend_vld_nxt;
      phase       <= phase_nxt;
      cycle_cnt   <= cnt_nxt;
      osc_out     <= osc_nxt;
      period_done <= done_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    act_nxt      = act;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    phase_nxt    = phase;
    cnt_nxt      = cycle_cnt;
    done_nxt     = 1'b0;
    apply        = 1'b0;

    case (state)
      IDLE: begin
        apply = pend_vld;
        if (en) begin
          state_nxt = HIGH;
          phase_nxt = '0;
        end
      end

      HIGH: begin
        if (!en) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (tick) begin
          if (phase == last_idx(act.high_len)) begin
            state_nxt = LOW;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + LEN_W'(1);
          end
        end
      end

      LOW: begin
        if (!en) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (tick) begin
          if (phase == last_idx(act.low_len)) begin
            state_nxt = HIGH;
            phase_nxt = '0;
            done_nxt  = 1'b1;
            cnt_nxt   = cycle_cnt + CNT_W'(1);
            apply     = pend_vld;
          end else begin
            phase_nxt = phase + LEN_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase

    // Apply consumes the old pending set; a load in the same cycle refills
    // the shadow and keeps it valid for the following boundary.
    if (apply) begin
      act_nxt      = pend;
      pend_vld_nxt = 1'b0;
    end
    if (load) begin
      pend_nxt.high_len = high_len;
      pend_nxt.low_len  = low_len;
      pend_nxt.prescale = prescale;
      pend_vld_nxt      = 1'b1;
    end

    osc_nxt  = (state_nxt == HIGH);
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_astable_osc_core.sv
// Self-checking bench for astable_osc_core: directed timing checks plus randomized
// stimulus compared every cycle against a phase-duration model.
module tb_astable_osc_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] high_len = '0;
  logic [7:0] low_len = '0;
  logic [7:0] prescale = '0;
  logic       osc_out;
  logic       period_done;
  logic [7:0] cycle_cnt;
  logic       busy;

  astable_osc_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .high_len    (high_len),
    .low_len     (low_len),
    .prescale    (prescale),
    .load        (load),
    .osc_out     (osc_out),
    .period_done (period_done),
    .cycle_cnt   (cycle_cnt),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "running / in HIGH / clk cycles left in this phase" instead of
  // tick and phase counters: a phase simply lasts max(len,1)*(prescale+1) cycles.
  int m_run, m_hi, m_rem, m_pd, m_cnt;
  int m_ah, m_al, m_ap;   // active settings
  int m_ph, m_pl, m_pp;   // pending settings
  int m_pv;               // pending valid

  function automatic int dur(input int len, input int pre);
    return ((len == 0) ? 1 : len) * (pre + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int run, hi, rem, pd, cnt, ah, al, ap, pv;
    bit apply, enter_hi;
    if (!rst_n) begin
      m_run <= 0; m_hi <= 0; m_rem <= 0; m_pd <= 0; m_cnt <= 0;
      m_ah <= 0; m_al <= 0; m_ap <= 0;
      m_ph <= 0; m_pl <= 0; m_pp <= 0; m_pv <= 0;
    end else begin
      run = m_run; hi = m_hi; rem = m_rem; pd = 0; cnt = m_cnt;
      ah = m_ah; al = m_al; ap = m_ap; pv = m_pv;
      apply = 0; enter_hi = 0;
      if (run == 0) begin
        apply = (pv != 0);
        if (en) begin
          run = 1; hi = 1; enter_hi = 1;
        end
      end else if (!en) begin
        run = 0; hi = 0;
      end else begin
        rem = rem - 1;
        if (rem == 0) begin
          if (hi != 0) begin
            hi = 0;
            rem = dur(al, ap);
          end else begin
            hi = 1; pd = 1; enter_hi = 1;
            cnt = (cnt + 1) % 256;
            apply = (pv != 0);
          end
        end
      end
      if (apply) begin
        ah = m_ph; al = m_pl; ap = m_pp; pv = 0;
      end
      if (enter_hi) rem = dur(ah, ap);
      if (load) begin
        m_ph <= int'(high_len); m_pl <= int'(low_len); m_pp <= int'(prescale);
        pv = 1;
      end
      m_run <= run; m_hi <= hi; m_rem <= rem; m_pd <= pd; m_cnt <= cnt;
      m_ah <= ah; m_al <= al; m_ap <= ap; m_pv <= pv;
    end
  end

  // Every cycle out of reset: {osc_out, busy, period_done, cycle_cnt} vs model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_cycle", int'({osc_out, busy, period_done, cycle_cnt}),
            ((m_run & m_hi) << 10) | (m_run << 9) | (m_pd << 8) | m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit tr_osc[$];
  bit tr_pd[$];
  int runs[8];
  int pd_a, pd_b;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int h, input int l, input int p);
    high_len = 8'(h); low_len = 8'(l); prescale = 8'(p);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Sample n cycles of osc_out/period_done, then derive run lengths and the
  // first two period_done positions.
  task automatic capture(input int n);
    int k;
    tr_osc.delete();
    tr_pd.delete();
    repeat (n) begin
      @(negedge clk);
      tr_osc.push_back(osc_out);
      tr_pd.push_back(period_done);
    end
    for (int i = 0; i < 8; i++) runs[i] = 0;
    pd_a = -1; pd_b = -1; k = 0;
    for (int i = 0; i < tr_osc.size(); i++) begin
      if (i > 0 && tr_osc[i] != tr_osc[i-1]) k++;
      if (k < 8) runs[k]++;
      if (tr_pd[i]) begin
        if (pd_a < 0) pd_a = i;
        else if (pd_b < 0) pd_b = i;
      end
    end
  endtask

  task automatic restart(input int h, input int l, input int p);
    en = 1'b0;
    step();
    do_load(h, l, p);
    step();
    en = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, seen;
    bit found;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_osc", osc_out, 0);
    check("rst_busy", busy, 0);
    check("rst_pd", period_done, 0);
    check("rst_cnt", cycle_cnt, 0);
    #1 rst_n = 1'b1;
    step();

    // Basic timing 3/2, prescale 0
    do_load(3, 2, 0);
    step();
    en = 1'b1;
    step();
    check("basic_busy", busy, 1);
    capture(25);
    check("basic_high0", runs[0], 3);
    check("basic_low0", runs[1], 2);
    check("basic_high1", runs[2], 3);
    check("basic_low1", runs[3], 2);
    check("basic_pd_first", pd_a, 5);
    check("basic_pd_period", pd_b - pd_a, 5);
    check("basic_cnt4", cycle_cnt, 4);

    // Prescaler: 2/1 with divide-by-4
    restart(2, 1, 3);
    capture(30);
    check("pre_high", runs[0], 8);
    check("pre_low", runs[1], 4);
    check("pre_pd_period", pd_b - pd_a, 12);

    // Zero lengths clamp to 1
    restart(0, 0, 0);
    capture(10);
    check("zero_high", runs[0], 1);
    check("zero_low", runs[1], 1);
    check("zero_high2", runs[2], 1);
    check("zero_pd_period", pd_b - pd_a, 2);

    // Shadowed update loaded mid-HIGH
    restart(4, 4, 0);
    step();
    do_load(1, 1, 0);
    capture(14);
    check("shadow_high_rest", runs[0], 2);
    check("shadow_low_old", runs[1], 4);
    check("shadow_high_new", runs[2], 1);
    check("shadow_low_new", runs[3], 1);

    // Load landing on the LOW->HIGH boundary: applies one period later
    restart(4, 4, 0);
    repeat (7) step();
    do_load(1, 1, 0);
    capture(14);
    check("bnd_high_old", runs[0], 4);
    check("bnd_low_old", runs[1], 4);
    check("bnd_high_new", runs[2], 1);
    check("bnd_low_new", runs[3], 1);

    // Randomized settings, loads and enable drops against the model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 39) != 0);
      load = ($urandom_range(0, 9) == 0);
      high_len = 8'($urandom_range(0, 5));
      low_len = 8'($urandom_range(0, 5));
      prescale = 8'($urandom_range(0, 3));
      step();
    end
    load = 1'b0;

    // Wrap: 256 periods of 1/1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    en = 1'b0;
    step();
    do_load(1, 1, 0);
    step();
    en = 1'b1;
    step();
    seen = 0;
    prev = cycle_cnt;
    for (int i = 0; i < 700 && seen == 0; i++) begin
      @(negedge clk);
      if (prev == 255 && cycle_cnt == 0) seen = 1;
      prev = cycle_cnt;
    end
    check("wrap_255_to_0", seen, 1);

    // Asynchronous reset pulsed mid-HIGH
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (osc_out && cycle_cnt >= 2) found = 1;
    end
    check("arst_setup_found", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_osc", osc_out, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", cycle_cnt, 0);
    #1 rst_n = 1'b1;
    step();

    // Disable during LOW at cycle_cnt=5, then re-enable
    do_load(2, 2, 0);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (cycle_cnt == 5 && !osc_out && busy) found = 1;
    end
    check("dis_setup_found", found, 1);
    #1 en = 1'b0;
    @(posedge clk);
    #1;
    check("dis_osc", osc_out, 0);
    check("dis_busy", busy, 0);
    check("dis_cnt", cycle_cnt, 5);
    check("dis_pd", period_done, 0);
    step();
    check("dis_cnt_hold", cycle_cnt, 5);
    en = 1'b1;
    step();
    capture(6);
    check("reen_high", runs[0], 2);
    check("reen_low", runs[1], 2);
    check("reen_cnt", cycle_cnt, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
